// File: rtl/pwm_deadtime_if.sv
// Control and gate-drive bundle for the pwm_deadtime stage.
// The master side drives phase, enable, dead time and fault controls; the slave returns gate drives and status.
interface pwm_deadtime_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 en;
  logic                 pwm_in;
  logic [CNT_WIDTH-1:0] dt;
  logic                 fault;
  logic                 clr_fault;
  logic                 gate_hi;
  logic                 gate_lo;
  logic                 dead_active;
  logic                 fault_latched;

  modport master (
    output en, pwm_in, dt, fault, clr_fault,
    input  gate_hi, gate_lo, dead_active, fault_latched
  );

  modport slave (
    input  en, pwm_in, dt, fault, clr_fault,
    output gate_hi, gate_lo, dead_active, fault_latched
  );
endinterface

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: turns one PWM phase into a complementary gate pair,
// with an all-off gap at every transition and a sticky fault shutdown.
module pwm_deadtime #(
  parameter int CNT_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  pwm_deadtime_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEAD, HI, LO} state_t;

  state_t               state, state_nx;
  logic                 target, target_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic [CNT_WIDTH-1:0] reload;
  logic                 fault_q, fault_nx;

  // A dead time of zero still costs one cycle, so the reload value is max(dt,1)-1.
  assign reload = (bus.dt == '0) ? '0 : bus.dt - CNT_WIDTH'(1);

  // NOTE: every variable gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    cnt_nx    = cnt;
    fault_nx  = fault_q;

    if (bus.fault) begin
      fault_nx = 1'b1;
      state_nx = IDLE;
    end else begin
      if (bus.clr_fault) fault_nx = 1'b0;

      if (!bus.en) begin
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE: if (!fault_q) begin
            state_nx  = DEAD;
            target_nx = bus.pwm_in;
            cnt_nx    = reload;
          end
          HI: if (!bus.pwm_in) begin
            state_nx  = DEAD;
            target_nx = 1'b0;
            cnt_nx    = reload;
          end
          LO: if (bus.pwm_in) begin
            state_nx  = DEAD;
            target_nx = 1'b1;
            cnt_nx    = reload;
          end
          DEAD: begin
            // A phase flip inside the gap restarts it, swallowing pulses shorter than the dead time.
            if (bus.pwm_in != target) begin
              target_nx = bus.pwm_in;
              cnt_nx    = reload;
            end else if (cnt == '0) begin
              state_nx = target ? HI : LO;
            end else begin
              cnt_nx = cnt - CNT_WIDTH'(1);
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      target            <= 1'b0;
      cnt               <= '0;
      fault_q           <= 1'b0;
      bus.gate_hi       <= 1'b0;
      bus.gate_lo       <= 1'b0;
      bus.dead_active   <= 1'b0;
      bus.fault_latched <= 1'b0;
    end else begin
      state             <= state_nx;
      target            <= target_nx;
      cnt               <= cnt_nx;
      fault_q           <= fault_nx;
      bus.gate_hi       <= (state_nx == HI);
      bus.gate_lo       <= (state_nx == LO);
      bus.dead_active   <= (state_nx == DEAD);
      bus.fault_latched <= fault_nx;
    end
  end

endmodule
